pc_seq: RTL and testbench

Parametrised program-counter sequencer, successor to the single-register `pc` (load/hold only). Each enabled cycle it increments, jumps absolute, branches relative, calls or returns. Calls and returns use a built-in return-address stack of configurable depth. It sits at the head of the fetch path and drives the instruction-memory address; sticky flags report stack overflow and underflow to the control logic.

---
 rtl/pc_seq_if.sv | 37 +++
 rtl/pc_seq.sv | 125 ++++++++++++
 tb/tb_pc_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - control/status bundle between fetch control and the PC sequencer
//
// Purpose: groups the sequencer's command inputs and registered status outputs.
// Parameters must match the ones given to pc_seq.
// Signals:
//   en        advance enable (0 = stall)
//   op        0 INC, 1 JMP, 2 BR, 3 CALL, 4 RET, 5-7 behave as INC
//   cond      taken qualifier for JMP/BR
//   in        JMP/CALL target or BR signed offset
//   out       current PC
//   depth     occupied return-stack entries
//   overflow  sticky: CALL with full stack
//   underflow sticky: RET with empty stack
// Modports: master drives commands (control logic / bench), slave is the sequencer.
interface pc_seq_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                       en;
    logic [2:0]                 op;
    logic                       cond;
    logic [WIDTH-1:0]           in;
    logic [WIDTH-1:0]           out;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output en, op, cond, in,
        input  out, depth, overflow, underflow
    );

    modport slave (
        input  en, op, cond, in,
        output out, depth, overflow, underflow
    );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with circular return-address stack
//
// Purpose: each enabled cycle the PC increments, jumps, branches relative,
// calls (pushing the return address) or returns (popping it). All outputs
// are registered; there is no combinational path from inputs to outputs.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (overrides en/op)
//   bus   pc_seq_if.slave: en/op/cond/in commands, out/depth/overflow/underflow status
module pc_seq #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0,
    parameter int STEP       = 1
) (
    input  logic    clk,
    input  logic    rst,
    pc_seq_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_ADDR);

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] top_ptr, next_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push;
    logic             full, empty;

    assign seq_pc = pc_q + STEP_W;
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);

    // wr_ptr always names the slot the next push will write; the newest
    // entry therefore lives one slot behind it, modulo DEPTH.
    assign top_ptr  = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - 1'b1;
    assign next_ptr = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;

        if (bus.en) begin
            case (bus.op)
                OP_JMP: pc_d = bus.cond ? bus.in : seq_pc;
                // Branch offset is relative to the current PC, not PC+STEP.
                OP_BR:  pc_d = bus.cond ? pc_q + bus.in : seq_pc;
                OP_CALL: begin
                    push     = 1'b1;
                    pc_d     = bus.in;
                    wr_ptr_d = next_ptr;
                    // A full stack keeps its count; the push lands on the
                    // oldest slot, which the circular pointer already names.
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d        = seq_pc;
                        underflow_d = 1'b1;
                    end else begin
                        pc_d     = stack_mem[top_ptr];
                        wr_ptr_d = top_ptr;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_mem[wr_ptr_q] <= seq_pc;
        end
    end

    assign bus.out       = pc_q;
    assign bus.depth     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq
module tb_pc_seq;

    localparam logic [2:0] INC  = 3'd0;
    localparam logic [2:0] JMP  = 3'd1;
    localparam logic [2:0] BR   = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pc_seq_if #(.WIDTH(16), .DEPTH(4)) bus ();

    pc_seq #(
        .WIDTH(16), .DEPTH(4), .RESET_ADDR(0), .STEP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc,
                               input logic [2:0] dep, input logic ovf, input logic unf);
        check({tag, ".out"},       32'(bus.out),       32'(pc));
        check({tag, ".depth"},     32'(bus.depth),     32'(dep));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
    endtask

    // Apply one cycle of stimulus and sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [2:0] o, input logic c, input logic [15:0] i);
        bus.en   = e;
        bus.op   = o;
        bus.cond = c;
        bus.in   = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.op   = INC;
        bus.cond = 1'b0;
        bus.in   = '0;

        // Reset with en=1 and a CALL present: reset must win.
        step(1'b1, CALL, 1'b0, 16'h1234);
        check_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        step(1'b1, INC, 1'b0, 16'h0000); check("inc1", 32'(bus.out), 32'h1);
        step(1'b1, INC, 1'b0, 16'h0000); check("inc2", 32'(bus.out), 32'h2);
        step(1'b1, INC, 1'b0, 16'h0000); check("inc3", 32'(bus.out), 32'h3);

        // Stall holds even with a taken JMP presented.
        step(1'b0, JMP, 1'b1, 16'h0050); check("stall1", 32'(bus.out), 32'h3);
        step(1'b0, JMP, 1'b1, 16'h0050); check_state("stall2", 16'h0003, 3'd0, 1'b0, 1'b0);
        step(1'b1, JMP, 1'b1, 16'h0050); check("jmp_taken", 32'(bus.out), 32'h50);

        step(1'b1, BR, 1'b0, 16'hFFFE);  check("br_not_taken", 32'(bus.out), 32'h51);
        step(1'b1, BR, 1'b1, 16'hFFFE);  check("br_back2", 32'(bus.out), 32'h4F);
        step(1'b1, JMP, 1'b0, 16'h9999); check("jmp_not_taken", 32'(bus.out), 32'h50);
        step(1'b1, 3'd7, 1'b1, 16'h9999); check("reserved_op7", 32'(bus.out), 32'h51);
        step(1'b1, JMP, 1'b1, 16'hFFFF); check("jmp_ffff", 32'(bus.out), 32'hFFFF);
        step(1'b1, INC, 1'b0, 16'h0000);
        check_state("inc_wrap", 16'h0000, 3'd0, 1'b0, 1'b0);

        // Nested calls and returns.
        step(1'b1, JMP, 1'b1, 16'h0010);
        step(1'b1, CALL, 1'b0, 16'h0100); check_state("call1", 16'h0100, 3'd1, 1'b0, 1'b0);
        step(1'b1, CALL, 1'b0, 16'h0200); check_state("call2", 16'h0200, 3'd2, 1'b0, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ret1", 16'h0101, 3'd1, 1'b0, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ret2", 16'h0011, 3'd0, 1'b0, 1'b0);

        // Overflow: five calls into a 4-deep stack.
        step(1'b1, JMP, 1'b1, 16'h0010);
        step(1'b1, CALL, 1'b0, 16'h0020);
        step(1'b1, CALL, 1'b0, 16'h0030);
        step(1'b1, CALL, 1'b0, 16'h0040);
        step(1'b1, CALL, 1'b0, 16'h0050); check_state("call_full", 16'h0050, 3'd4, 1'b0, 1'b0);
        step(1'b1, CALL, 1'b0, 16'h0060); check_state("call_ovf", 16'h0060, 3'd4, 1'b1, 1'b0);
        step(1'b0, RET, 1'b0, 16'h0000);  check_state("stall_ret", 16'h0060, 3'd4, 1'b1, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ovf_ret1", 16'h0051, 3'd3, 1'b1, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ovf_ret2", 16'h0041, 3'd2, 1'b1, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ovf_ret3", 16'h0031, 3'd1, 1'b1, 1'b0);
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("ovf_ret4", 16'h0021, 3'd0, 1'b1, 1'b0);

        // Reset mid-sequence drops the stack and clears the flags.
        step(1'b1, CALL, 1'b0, 16'h0100);
        step(1'b1, CALL, 1'b0, 16'h0200); check("pre_rst_depth", 32'(bus.depth), 32'd2);
        rst = 1'b1;
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("mid_rst", 16'h0000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, RET, 1'b0, 16'h0000);  check_state("unf_ret", 16'h0001, 3'd0, 1'b0, 1'b1);
        step(1'b1, INC, 1'b0, 16'h0000);  check_state("unf_sticky1", 16'h0002, 3'd0, 1'b0, 1'b1);
        step(1'b1, INC, 1'b0, 16'h0000);  check_state("unf_sticky2", 16'h0003, 3'd0, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, INC, 1'b0, 16'h0000);  check_state("final_rst", 16'h0000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
